// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one shared uart_tx: accepts a byte from the winning
// requester, builds the framed word, issues tx_start and waits for tx_done or a watchdog abort.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_EN      = 0,
    parameter int unsigned PARITY_ODD     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned FRAME_BITS    = 2 + DATA_BITS + PARITY_EN,
    localparam int unsigned IdW           = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [FRAME_BITS-1:0]          frame_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [IdW-1:0]                 grant_id,
    output logic                           active,
    output logic                           timeout_err
);

    localparam logic [IdW:0]   NumReqW    = (IdW + 1)'(NUM_REQ);
    localparam logic [IdW-1:0] LastReq    = IdW'(NUM_REQ - 1);
    localparam logic [23:0]    TimeoutLim = 24'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IdW-1:0]          last_grant_q, last_grant_d;
    logic [IdW-1:0]          grant_id_q, grant_id_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic                    tx_start_q, tx_start_d;
    logic                    active_q, active_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [23:0]             wd_cnt_q, wd_cnt_d;

    logic                    win_found;
    logic [IdW-1:0]          win_idx;
    logic [IdW:0]            cand;
    logic [DATA_BITS-1:0]    win_data;
    logic [FRAME_BITS-1:0]   frame_next;
    logic                    accept;
    logic                    wd_expired;

    // Search starts just after the previous owner and wraps, so the first valid hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant_q} + (IdW + 1)'(i);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!win_found && req_valid[cand[IdW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdW'(i)) begin
                win_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Start bit low, data LSB-first, optional parity, stop bit high (left from the all-ones fill).
    always_comb begin
        frame_next                = '1;
        frame_next[0]             = 1'b0;
        frame_next[DATA_BITS:1]   = win_data;
        if (PARITY_EN != 0) begin
            frame_next[DATA_BITS+1] = (^win_data) ^ PARITY_ODD[0];
        end
    end

    assign accept     = (state_q == StIdle) && win_found && !tx_busy;
    assign wd_expired = (wd_cnt_q == TimeoutLim);

    always_comb begin
        req_ready = '0;
        if (accept && reset_n) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done || wd_expired) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and datapath next values; tx_done takes priority over an expiring watchdog.
    always_comb begin
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        active_d      = active_q;
        grant_id_d    = grant_id_q;
        frame_d       = frame_q;
        last_grant_d  = last_grant_q;
        wd_cnt_d      = wd_cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_start_d = 1'b1;
                    active_d   = 1'b1;
                    grant_id_d = win_idx;
                    frame_d    = frame_next;
                end
            end
            StStart: begin
                wd_cnt_d = '0;
            end
            StWait: begin
                if (tx_done) begin
                    active_d     = 1'b0;
                    last_grant_d = grant_id_q;
                end else if (wd_expired) begin
                    active_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    last_grant_d  = grant_id_q;
                end else begin
                    wd_cnt_d = wd_cnt_q + 24'd1;
                end
            end
            default: begin
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            active_q      <= 1'b0;
            grant_id_q    <= '0;
            frame_q       <= '1;
            last_grant_q  <= LastReq;
            wd_cnt_q      <= '0;
        end else begin
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
            active_q      <= active_d;
            grant_id_q    <= grant_id_d;
            frame_q       <= frame_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign timeout_err = timeout_err_q;
    assign active      = active_q;
    assign grant_id    = grant_id_q;
    assign frame_data  = frame_q;

    a_start_single : assert property (@(posedge clk) disable iff (!reset_n)
        tx_start |=> !tx_start);
    a_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single transfers plus hand-written
// sequences for watchdog, busy gating, mid-frame reset and round-robin fairness.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        tx_busy;
    logic        tx_done;

    logic [3:0]  req_ready, rdy_pe, rdy_po;
    logic [9:0]  frame_data;
    logic [10:0] frame_pe, frame_po;
    logic        tx_start, start_pe, start_po;
    logic [1:0]  grant_id, grant_pe, grant_po;
    logic        active, active_pe, active_po;
    logic        timeout_err, tmo_pe, tmo_po;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .frame_data(frame_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id), .active(active),
        .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .TIMEOUT_CYCLES(100)
    ) dut_pe (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_pe), .frame_data(frame_pe), .tx_start(start_pe),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_pe), .active(active_pe),
        .timeout_err(tmo_pe)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .TIMEOUT_CYCLES(100)
    ) dut_po (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_po), .frame_data(frame_po), .tx_start(start_po),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_po), .active(active_po),
        .timeout_err(tmo_po)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  ready;
        logic [1:0]  grant;
        logic [9:0]  frame;
        logic [10:0] fpe;
        logic [10:0] fpo;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One accept / start / wait / done transfer from IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        req_valid = v.valid;
        req_data  = v.data;
        #1;
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'(v.ready));
        chk($sformatf("v%0d_ready_pe", idx), 32'(rdy_pe), 32'(v.ready));
        chk($sformatf("v%0d_ready_po", idx), 32'(rdy_po), 32'(v.ready));
        chk($sformatf("v%0d_start_early", idx), 32'(tx_start), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk($sformatf("v%0d_start", idx), 32'(tx_start), 32'd1);
        chk($sformatf("v%0d_start_par", idx), 32'({start_pe, start_po}), 32'b11);
        chk($sformatf("v%0d_frame", idx), 32'(frame_data), 32'(v.frame));
        chk($sformatf("v%0d_frame_pe", idx), 32'(frame_pe), 32'(v.fpe));
        chk($sformatf("v%0d_frame_po", idx), 32'(frame_po), 32'(v.fpo));
        chk($sformatf("v%0d_grant", idx), 32'(grant_id), 32'(v.grant));
        chk($sformatf("v%0d_grant_par", idx), 32'({grant_pe, grant_po}), 32'({v.grant, v.grant}));
        chk($sformatf("v%0d_active", idx), 32'({active, active_pe, active_po}), 32'b111);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_start_once", idx), 32'(tx_start), 32'd0);
        chk($sformatf("v%0d_active_wait", idx), 32'(active), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk($sformatf("v%0d_active_fall", idx), 32'(active), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int t_done;
        logic seen;

        vecs[0] = '{4'b0001, 32'h0000_0055, 4'b0001, 2'd0, 10'h2AA, 11'h4AA, 11'h6AA};
        vecs[1] = '{4'b1111, 32'h4433_8011, 4'b0010, 2'd1, 10'h300, 11'h700, 11'h500};
        vecs[2] = '{4'b1011, 32'hFF22_3344, 4'b1000, 2'd3, 10'h3FE, 11'h5FE, 11'h7FE};
        vecs[3] = '{4'b0110, 32'h1122_0033, 4'b0010, 2'd1, 10'h200, 11'h400, 11'h600};
        vecs[4] = '{4'b0011, 32'h0102_03A5, 4'b0001, 2'd0, 10'h34A, 11'h54A, 11'h74A};
        vecs[5] = '{4'b0001, 32'h9988_7701, 4'b0001, 2'd0, 10'h202, 11'h602, 11'h402};
        vecs[6] = '{4'b0001, 32'hEEDD_CC07, 4'b0001, 2'd0, 10'h20E, 11'h60E, 11'h40E};

        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;

        // Reset values, with requests pending to show req_ready is gated.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_frame", 32'(frame_data), 32'h3FF);
        chk("rst_frame_pe", 32'(frame_pe), 32'h7FF);
        @(negedge clk);
        req_valid = 4'b0000;
        reset_n   = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Watchdog: requester 2 served, tx_done never arrives.
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h0012_3456;
        #1;
        chk("wd_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("wd_start", 32'(tx_start), 32'd1);
        chk("wd_grant", 32'(grant_id), 32'd2);
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            #1;
            if (timeout_err) seen = 1'b1;
        end
        chk("wd_latency", 32'(n), 32'd102);
        chk("wd_active", 32'(active), 32'd0);
        chk("wd_par_err", 32'({tmo_pe, tmo_po}), 32'b11);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("wd_pulse_width", 32'(timeout_err), 32'd0);
        chk("wd_next_ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("wd_next_grant", 32'(grant_id), 32'd3);
        chk("wd_next_start", 32'(tx_start), 32'd1);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("wd_next_done", 32'(active), 32'd0);

        // tx_done on the very cycle the watchdog would expire: no error.
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("co_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("co_start", 32'(tx_start), 32'd1);
        repeat (100) @(negedge clk);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("co_no_err", 32'(timeout_err), 32'd0);
        chk("co_active", 32'(active), 32'd0);
        @(negedge clk);
        #1;
        chk("co_no_err_late", 32'(timeout_err), 32'd0);

        // Busy gate.
        @(negedge clk);
        tx_busy   = 1'b1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_C300;
        #1;
        chk("busy_ready0", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("busy_ready%0d", i + 1), 32'(req_ready), 32'd0);
            chk($sformatf("busy_start%0d", i + 1), 32'(tx_start), 32'd0);
        end
        @(negedge clk);
        tx_busy = 1'b0;
        #1;
        chk("busy_release_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("busy_start", 32'(tx_start), 32'd1);
        chk("busy_grant", 32'(grant_id), 32'd1);
        chk("busy_frame", 32'(frame_data), 32'h386);

        // Reset in the middle of WAIT.
        @(negedge clk);
        #1;
        chk("mid_wait_active", 32'(active), 32'd1);
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        reset_n   = 1'b0;
        #1;
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_grant", 32'(grant_id), 32'd0);
        chk("mid_rst_frame", 32'(frame_data), 32'h3FF);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(req_ready), 32'b0001);

        // Fairness with a simple uart_tx behaviour: busy for a few cycles, then done.
        t_done = 0;
        for (int f = 0; f < 6; f++) begin
            n    = 0;
            seen = 1'b0;
            while (n < 10 && !seen) begin
                @(negedge clk);
                n++;
                #1;
                if (tx_start) seen = 1'b1;
            end
            chk($sformatf("fair%0d_seen", f), 32'(seen), 32'd1);
            chk($sformatf("fair%0d_grant", f), 32'(grant_id), 32'(f % 4));
            if (f > 0) begin
                chk($sformatf("fair%0d_gap", f), 32'(cyc - t_done), 32'd2);
            end
            tx_busy = 1'b1;
            repeat (4) @(negedge clk);
            @(negedge clk);
            tx_done = 1'b1;
            tx_busy = 1'b0;
            t_done  = cyc;
            @(negedge clk);
            tx_done = 1'b0;
        end
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among up to `NUM_REQ` byte requesters. It accepts a byte from the winning requester and builds the full UART frame: start bit, data LSB-first, optional parity, and stop bit. It then pulses `tx_start` and holds off further grants until the transmitter reports `tx_done`, or until a watchdog timeout expires. It sits between the host-side byte producers and `uart_tx`, and is the only driver of `uart_tx`'s `frame_data` and `tx_start`.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `DATA_BITS`, default 8: data bits per frame.
- `PARITY_EN`, default 0: 1 inserts a parity bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `TIMEOUT_CYCLES`, default 65535: number of WAIT cycles without `tx_done` before abort. Must be < 2^24.
- `FRAME_BITS`, derived as 2+DATA_BITS+PARITY_EN. Not overridable. Must equal the connected `uart_tx` FRAME_BITS.

- `clk`, in, 1: single system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: bit i high means requester i has a byte.
- `req_data`, in, NUM_REQ*DATA_BITS: requester i data is at `[i*DATA_BITS +: DATA_BITS]`.
- `req_ready`, out, NUM_REQ: one-hot. Valid and ready high in the same cycle means the byte is accepted.
- `frame_data`, out, FRAME_BITS: frame presented to `uart_tx`.
- `tx_start`, out, 1: one-cycle start pulse to `uart_tx`.
- `tx_busy`, in, 1: from `uart_tx`.
- `tx_done`, in, 1: one-cycle completion pulse from `uart_tx`.
- `grant_id`, out, clog2(NUM_REQ): requester that owns the current or most recent frame.
- `active`, out, 1: high from accept until return to IDLE.
- `timeout_err`, out, 1: one-cycle pulse on watchdog abort.

## Operation
- **States:** IDLE, START, WAIT. Encoded in 2 bits; the unused code returns to IDLE.
- **IDLE, requester selection:**
  - A winner exists when `|req_valid` is high and `tx_busy` is 0.
  - Search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - The first requester with valid set wins.
- **IDLE, accept actions:**
  - `req_ready` is combinational: the winner's bit only, and only in IDLE with `reset_n` high.
  - On accept, register `frame_data`, set `grant_id` to the winner, set `active` to 1, and go to START.
- **Frame construction:**
  - bit 0 = 0 (start bit).
  - bits [DATA_BITS:1] = data.
  - If PARITY_EN, bit DATA_BITS+1 = `^data` XOR PARITY_ODD.
  - bit FRAME_BITS-1 = 1 (stop bit).
- **START:** `tx_start` is 1 for this cycle only. Next state is WAIT. Clear the watchdog counter (24 bits).
- **WAIT, normal completion:** on `tx_done` = 1, go to IDLE, set `last_grant` to `grant_id`, and clear `active`.
- **WAIT, watchdog:**
  - Each WAIT cycle without `tx_done` increments the counter.
  - When the count reaches TIMEOUT_CYCLES, go to IDLE, pulse `timeout_err`, clear `active`, and advance `last_grant` to `grant_id`.
  - The aborted byte is dropped; there is no retry.
  - If `tx_done` and the timeout limit coincide in the same cycle, `tx_done` wins and no error is raised.
- **Other boundaries:**
  - `frame_data` holds its value from accept until the next accept.
  - `tx_busy` high in IDLE blocks all grants.
  - `req_valid` dropping during START or WAIT has no effect.
  - Requesters not granted see `req_ready` = 0 and must hold `req_valid` and their data.
- **Reset values, with `reset_n` low at any time (including mid-frame):**
  - state IDLE.
  - `tx_start` 0, `req_ready` 0, `active` 0, `timeout_err` 0, `grant_id` 0.
  - `frame_data` all ones.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - The watchdog counter is cleared.
  - The in-flight byte is lost.

## Timing
- Accept at cycle T (IDLE, handshake). `tx_start` = 1 in cycle T+1 with `frame_data` already stable. WAIT begins at T+2.
- `tx_done` in cycle D puts IDLE in D+1. The earliest next accept is D+1, and the next `tx_start` is D+2.
- `tx_start` is never asserted in two consecutive cycles, nor more than once per accept.
- `timeout_err` is asserted in the first IDLE cycle after abort, exactly TIMEOUT_CYCLES+2 cycles after `tx_start`.
- All outputs except `req_ready` are registered.

## Test plan
- **Single byte.** Stimulus: NUM_REQ=4, PARITY_EN=0, `req_valid`=0001, data 0x55. Response: `req_ready`=0001 in the same cycle; `tx_start` pulse next cycle; `frame_data`=0x2AA; `grant_id`=0; `active` falls the cycle after `tx_done`.
- **Fairness.** Stimulus: all four requesters valid continuously with the `uart_tx` model attached. Response: grant order 0,1,2,3,0,1; each `tx_start` exactly 2 cycles after the previous `tx_done`.
- **Parity.** Stimulus: DATA_BITS=8, data 0x07. Response: PARITY_EN=1 with PARITY_ODD=0 gives `frame_data`=0x60E; PARITY_ODD=1 gives 0x40E.
- **Watchdog.** Stimulus: TIMEOUT_CYCLES=100, `tx_done` held at 0. Response: `timeout_err` pulses once, 102 cycles after `tx_start`; then requester `grant_id`+1 is served.
- **Busy gate.** Stimulus: `tx_busy`=1 forced in IDLE with `req_valid`=0010. Response: `req_ready`=0 and no `tx_start` while busy; grant happens in the cycle `tx_busy` falls.
- **Reset mid-WAIT.** Stimulus: pulse `reset_n` low during WAIT. Response: all outputs immediately take their reset values; with all requesters valid, the first grant after release goes to requester 0.
